sprite_rom_arbiter: RTL and testbench

//  Shares one synchronous sprite ROM (32x32, palette-indexed) between N_REQ sprite

---
 rtl/sprite_arb_pkg.sv | 32 +++
 rtl/sprite_arb_rr_picker.sv | 48 ++++
 rtl/sprite_rom_arbiter.sv | 124 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite ROM arbiter.
// Widths of the 32x32 palette-indexed sprite ROM, response bundle, rr helper.
package sprite_arb_pkg;

  localparam int SPRITE_ADDR_W  = 10;
  localparam int SPRITE_DATA_W  = 4;
  localparam int SPRITE_ID_W    = 2;
  localparam int SPRITE_MAX_REQ = 32;

  typedef struct packed {
    logic                     valid;
    logic [SPRITE_ID_W-1:0]   id;
    logic [SPRITE_DATA_W-1:0] data;
  } sprite_rsp_t;

  // One-hot round-robin pick over the low n bits of valid,
  // searching ptr, ptr+1, ... mod n.
  function automatic logic [SPRITE_MAX_REQ-1:0] rr_pick(
    input logic [SPRITE_MAX_REQ-1:0] valid,
    input int                        ptr,
    input int                        n
  );
    logic [4:0] i;
    rr_pick = '0;
    for (int k = 0; k < n; k++) begin
      i = 5'((ptr + k) % n);
      if (valid[i] && rr_pick == '0)
        rr_pick[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/sprite_arb_rr_picker.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, rotate back.
// Ports: valid (requests), ptr (search start) -> grant (one-hot/zero), idx.
module sprite_arb_rr_picker
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot;
  logic             found;
  int               off;
  int               s;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = 0;
    s     = 0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= N_REQ)
        s = s - N_REQ;
      rot[k] = valid[s[ID_W-1:0]];
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = k;
      end
    end
    s = int'(ptr) + off;
    if (s >= N_REQ)
      s = s - N_REQ;
    if (found) begin
      idx        = s[ID_W-1:0];
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among N_REQ requesters.
// Ports: vga_clk, reset (sync, active-high), req_valid/req_addr/req_ready
// request side, rom_address/rom_q ROM side, rsp_valid/rsp_id/rsp_data responses.
// Optional macro SPRITE_ARB_PLAYER_PRIO_EN: requester 0 always wins when valid.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int ROM_LAT = 1,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    vga_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [N_REQ-1:0] pick_valid;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             hs;
  logic             ptr_adv;

  logic [ROM_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [ROM_LAT];

  sprite_arb_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .valid (pick_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  // Player bypasses the rotation and leaves rr_ptr untouched.
  always_comb begin
    pick_valid    = req_valid;
    pick_valid[0] = 1'b0;
    grant         = pick_grant;
    grant_idx     = pick_idx;
    if (req_valid[0]) begin
      grant     = '0;
      grant[0]  = 1'b1;
      grant_idx = '0;
    end
  end
  assign ptr_adv = hs & ~req_valid[0];
`else
  always_comb begin
    pick_valid = req_valid;
    grant      = pick_grant;
    grant_idx  = pick_idx;
  end
  assign ptr_adv = hs;
`endif

  assign req_ready = reset ? '0 : grant;
  assign hs        = |req_ready;

  assign ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ?
                   '0 : grant_idx + 1'b1;

  always_comb begin
    rom_address = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i])
        rom_address = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (ptr_adv)
      rr_ptr <= ptr_nxt;
  end

  // Tags travel alongside the ROM read; the response register
  // is the final stage and samples rom_q when the tag arrives.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 0; k < ROM_LAT; k++)
        tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= grant_idx;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_v[ROM_LAT-1];
      if (tag_v[ROM_LAT-1]) begin
        rsp_id   <= tag_id[ROM_LAT-1];
        rsp_data <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 4;
  localparam int LAT = 1;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          vga_clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (LAT)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data)
  );

  always_ff @(posedge vga_clk)
    rom_q <= rom_address[3:0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    sprite_rsp_t rsp;
  } vec_t;

  vec_t tbl [17];

  task automatic row(input int k, input logic [3:0] v,
                     input logic [3:0] r, input logic rv,
                     input logic [1:0] id, input logic [3:0] d);
    tbl[k].valid     = v;
    tbl[k].ready     = r;
    tbl[k].rsp.valid = rv;
    tbl[k].rsp.id    = id;
    tbl[k].rsp.data  = d;
  endtask

  localparam logic [N*AW-1:0] TADDR =
    {10'h3F3, 10'h155, 10'h0A1, 10'h2C8};
  int dmap [4] = '{8, 1, 5, 3};

  typedef struct { int due; int id; int data; } exp_t;
  exp_t q [$];

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr, last_id, last_data, cyc, g, ex_id;
    logic rst;
    logic [3:0] v;
    logic [AW-1:0] a [N];
    exp_t e;

    row(0,  4'b0100, 4'b0100, 0, 0, 0);
    row(1,  4'b0000, 4'b0000, 0, 0, 0);
    row(2,  4'b0000, 4'b0000, 1, 2, 5);
    row(3,  4'b0000, 4'b0000, 0, 2, 5);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
    row(4,  4'b1111, 4'b0001, 0, 2, 5);
    row(5,  4'b1111, 4'b0001, 0, 2, 5);
    row(6,  4'b1111, 4'b0001, 1, 0, 8);
    row(7,  4'b1111, 4'b0001, 1, 0, 8);
    row(8,  4'b1111, 4'b0001, 1, 0, 8);
    row(9,  4'b0000, 4'b0000, 1, 0, 8);
    row(10, 4'b0000, 4'b0000, 1, 0, 8);
    row(11, 4'b0010, 4'b0010, 0, 0, 8);
    row(12, 4'b1010, 4'b1000, 0, 0, 8);
`else
    row(4,  4'b1111, 4'b1000, 0, 2, 5);
    row(5,  4'b1111, 4'b0001, 0, 2, 5);
    row(6,  4'b1111, 4'b0010, 1, 3, 3);
    row(7,  4'b1111, 4'b0100, 1, 0, 8);
    row(8,  4'b1111, 4'b1000, 1, 1, 1);
    row(9,  4'b0000, 4'b0000, 1, 2, 5);
    row(10, 4'b0000, 4'b0000, 1, 3, 3);
    row(11, 4'b0010, 4'b0010, 0, 3, 3);
    row(12, 4'b1010, 4'b1000, 0, 3, 3);
`endif
    row(13, 4'b1010, 4'b0010, 1, 1, 1);
    row(14, 4'b0000, 4'b0000, 1, 3, 3);
    row(15, 4'b0000, 4'b0000, 1, 1, 1);
    row(16, 4'b0000, 4'b0000, 0, 1, 1);

    // reset held with every requester asking
    reset     = 1'b1;
    req_valid = '1;
    req_addr  = TADDR;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_addr", rom_address, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      tick();
    end
    reset = 1'b0;

    for (int k = 0; k < 17; k++) begin
      req_valid = tbl[k].valid;
      @(negedge vga_clk);
      chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].ready);
      chk($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].rsp.valid);
      chk($sformatf("tbl%0d_rsp_id", k), rsp_id, tbl[k].rsp.id);
      chk($sformatf("tbl%0d_rsp_data", k), rsp_data, tbl[k].rsp.data);
      tick();
    end

    // handshake immediately followed by reset: response must vanish
    req_valid = 4'b0001;
    @(negedge vga_clk);
    chk("abort_ready", req_ready, 4'b0001);
    tick();
    reset     = 1'b1;
    req_valid = '0;
    @(negedge vga_clk);
    chk("abort_rst_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_id", rsp_id, 0);
      chk("abort_rsp_data", rsp_data, 0);
      tick();
    end

    // saturated load for 8 cycles from rr_ptr = 0
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge vga_clk);
      chk($sformatf("sat%0d_ready", k), req_ready,
          PRIO ? 32'd1 : (32'd1 << (k % 4)));
      if (k >= 2) begin
        ex_id = PRIO ? 0 : (k - 2) % 4;
        chk($sformatf("sat%0d_rsp_valid", k), rsp_valid, 1);
        chk($sformatf("sat%0d_rsp_id", k), rsp_id, ex_id);
        chk($sformatf("sat%0d_rsp_data", k), rsp_data, dmap[ex_id]);
      end
      tick();
    end

    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;

    ptr       = 0;
    last_id   = 0;
    last_data = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 39) == 0);
      v   = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        a[i] = AW'($urandom);
        req_addr[i*AW +: AW] = a[i];
      end
      reset     = rst;
      req_valid = v;
      @(negedge vga_clk);

      g = -1;
      if (!rst) begin
        if (PRIO && v[0]) begin
          g = 0;
        end else begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (!(PRIO && i == 0) && v[i] && g < 0)
              g = i;
          end
        end
      end
      chk("rnd_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("rnd_addr", rom_address, (g >= 0) ? 32'(a[g]) : 32'd0);

      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rnd_rsp_valid", rsp_valid, 1);
        chk("rnd_rsp_id", rsp_id, e.id);
        chk("rnd_rsp_data", rsp_data, e.data);
        last_id   = e.id;
        last_data = e.data;
      end else begin
        chk("rnd_rsp_valid", rsp_valid, 0);
        chk("rnd_rsp_id_hold", rsp_id, last_id);
        chk("rnd_rsp_data_hold", rsp_data, last_data);
      end

      if (rst) begin
        q.delete();
        ptr       = 0;
        last_id   = 0;
        last_data = 0;
      end else if (g >= 0) begin
        q.push_back('{cyc + LAT + 1, g, int'(a[g]) % 16});
        if (!(PRIO && g == 0))
          ptr = (g + 1) % N;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
